uctl_sys_ctrl_rx_mq: RTL
========================

Name: uctl_sys_ctrl_rx_mq

Overview:
Second-generation system-side read controller for the USB core. It accepts queued read requests from the register block, one per endpoint, and sequences the System Endpoint Controller through pointer fetch, header read, data read and buffer update for rdCount+1 packets per request. Against the first generation it adds:
- parametrised endpoint and count widths
- a request queue
- abort support
- per-request completion reporting with a transferred-packet count
It sits between the register block and the System Endpoint Controller.

Parameters:
EPW, 4, endpoint number width
CNTW, 4, packet-count field width; a request reads rdCount+1 packets
QDEPTH, 4, request queue depth (power of two, >=2)
QLW, 3, queue level width, equal to log2(QDEPTH)+1

Ports:
coreClk  in  1  core clock
uctl_rst_n  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous software reset
reg2sctrlRx_req  in  1  push request, single-cycle qualifier
reg2sctrlRx_epNum  in  EPW  request endpoint
reg2sctrlRx_rdCount  in  CNTW  packets minus one
reg2sctrlRx_listMode  in  1  list mode: pointer fetch only
reg2sctrlRx_abort  in  1  abort current request and flush the queue
sctrlRx2reg_reqRdy  out  1  queue not full
sctrlRx2reg_qLevel  out  QLW  queued requests, excluding the active one
sctrlRx2reg_updtRdBuf  out  1  completion pulse
sctrlRx2reg_doneEp  out  EPW  endpoint of the completed request
sctrlRx2reg_status  out  2  00 ok, 01 empty, 10 busy, 11 aborted/timeout
sctrlRx2reg_pktsDone  out  CNTW+1  packets transferred by the completed request
sepr2sctrlRx_rdPtrsRcvd / _bufEmpty / _hdrRdDn / _transferDn / _bufUpdtDn  in  1 each  endpoint controller handshakes
sctrlRx2sepr_inIdle / _getRdPtrs / _hdrRd / _rd / _updtRdBuf / _wrAddrEn  out  1 each  endpoint controller strobes
sctrlRx2sepr_epNum  out  EPW  active endpoint, registered

Behaviour:
- Reset values (async reset or sw_rst): state IDLE, queue empty, qLevel 0, reqRdy 1, all strobes 0, status 00, doneEp 0, pktsDone 0, sepr_epNum 0. sw_rst issues no completion pulse.
- Queue push:
  - Occurs when req=1 and reqRdy=1. A push while full is dropped; the register block must honour reqRdy.
  - Push and pop in the same cycle are legal; qLevel is unchanged.
- States: IDLE, RDPTR, RDHDR, RDDATA, UPDT, CMPL. Strobes are Moore outputs of the state, except wrAddrEn.
- IDLE:
  - inIdle=1; status 00 is held from the last completion.
  - If the queue is non-empty: pop the head, latch epNum/rdCount/listMode, clear the packet counter, pulse wrAddrEn for 1 cycle, go to RDPTR.
  - sepr_epNum is valid from the first RDPTR cycle.
- RDPTR: getRdPtrs=1 until rdPtrsRcvd.
  - listMode: go to CMPL, status 00, pktsDone 0.
  - Else if bufEmpty: go to CMPL, status 01 (the pktsDone count so far is preserved).
  - Else go to RDHDR.
- RDHDR: hdrRd=1 until hdrRdDn, then go to RDDATA.
- RDDATA: rd=1 until transferDn, then go to UPDT.
- UPDT: updtRdBuf=1 until bufUpdtDn. On bufUpdtDn, increment the packet counter.
  - If counter == rdCount: go to CMPL, status 00.
  - Else go to RDPTR.
- CMPL, one cycle: updtRdBuf pulse to the register block; doneEp, status and pktsDone are registered and held until the next CMPL. Then go to IDLE.
- sctrlRx2reg_status reads 10 whenever state is not IDLE/CMPL.
- Packet counter is CNTW+1 bits wide, so rdCount all-ones gives 2^CNTW packets without wrap. pktsDone equals counter value at CMPL.
- Abort (level sampled each cycle):
  - IDLE: flush queue only.
  - RDPTR/RDHDR: flush queue, go to CMPL with status 11.
  - RDDATA/UPDT: flush queue; finish the current packet (transferDn then bufUpdtDn, counter increments), then go to CMPL with status 11.
  - A request pushed in the same cycle as abort is discarded.
- Latency: request push in an empty IDLE queue → getRdPtrs asserted 2 cycles later.

Optional Feature:
UCTL_SCTRLRX_TMO_EN
- With the macro: parameter TMOW (default 12) and a per-state watchdog counter, cleared on every state change. If it reaches all-ones in RDPTR, RDHDR, RDDATA or UPDT, the block goes to CMPL with status 11 and a 1-cycle sctrlRx2reg_tmo pulse. The queue is not flushed.
- Without the macro: no counter, no sctrlRx2reg_tmo port; handshakes wait indefinitely.

Decomposition:
- Package uctl_sctrlrx_pkg holds the state encodings (3 bits) and the status codes (ST_OK, ST_EMPTY, ST_BUSY, ST_ABORT).
- One sub-module, uctl_sctrlrx_req_fifo: a synchronous FIFO of width EPW+CNTW+1 and depth QDEPTH, with flush, level and full/empty outputs.

Test Plan:
- Push ep=3, rdCount=0; the responder acks each handshake after 2 cycles → exactly one header/data/update sequence; CMPL gives doneEp=3, status 00, pktsDone 1.
- Push ep=5, rdCount=all-ones with CNTW=4 → 16 packets, then pktsDone 16 with no wrap; getRdPtrs re-asserts between packets.
- Push ep=2, rdCount=7; bufEmpty at the 4th rdPtrsRcvd → status 01, pktsDone 3.
- Push 5 requests with QDEPTH=4 while busy → reqRdy drops at qLevel 4, the 5th push is dropped, and the completions arrive in FIFO order.
- Abort asserted during RDDATA of packet 2 with 3 requests queued → that packet's transferDn/bufUpdtDn complete, status 11, pktsDone 2, qLevel 0, return to IDLE.
- With UCTL_SCTRLRX_TMO_EN and TMOW=4: hdrRdDn withheld → tmo pulse after 15 cycles in RDHDR, status 11, next queued request starts.

Source files
------------

// File: rtl/uctl_sctrlrx_pkg.sv
// Shared encodings for the second-generation system-side read controller:
// FSM state encoding and the completion status codes reported to the register block.
package uctl_sctrlrx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RDPTR  = 3'd1,
        RDHDR  = 3'd2,
        RDDATA = 3'd3,
        UPDT   = 3'd4,
        CMPL   = 3'd5
    } sctrlRxState_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_EMPTY = 2'b01;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

endpackage

// File: rtl/uctl_sctrlrx_req_fifo.sv
// Request queue for the read controller: first-word-fall-through synchronous FIFO
// with flush, occupancy level and full/empty flags. Storage is not reset; only the
// pointers are.
module uctl_sctrlrx_req_fifo #(
    parameter int W      = 9,
    parameter int QDEPTH = 4,
    parameter int QLW    = 3
) (
    input  logic           coreClk,
    input  logic           uctl_rst_n,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   wrData,
    output logic [W-1:0]   rdData,
    output logic [QLW-1:0] level,
    output logic           full,
    output logic           empty
);

    localparam int AW = QLW - 1;

    logic [W-1:0]   mem [QDEPTH];
    logic [QLW-1:0] wrPtr;
    logic [QLW-1:0] rdPtr;
    logic           doPush;
    logic           doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level  = wrPtr - rdPtr;
    assign full   = (level == QLW'(QDEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;
    assign rdData = mem[rdPtr[AW-1:0]];

    // Read/write pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge coreClk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge coreClk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/uctl_sys_ctrl_rx_mq.sv
// System-side read controller with request queue. Pops queued per-endpoint read
// requests and sequences the endpoint controller through pointer fetch, header
// read, data read and buffer update for rdCount+1 packets, then reports a
// completion (endpoint, status, packet count). Supports abort with queue flush.
// Optional watchdog: define UCTL_SCTRLRX_TMO_EN to add parameter TMOW and the
// sctrlRx2reg_tmo output.
module uctl_sys_ctrl_rx_mq
    import uctl_sctrlrx_pkg::*;
#(
    parameter int EPW    = 4,
    parameter int CNTW   = 4,
    parameter int QDEPTH = 4,
    parameter int QLW    = 3
`ifdef UCTL_SCTRLRX_TMO_EN
    ,parameter int TMOW  = 12
`endif
) (
    input  logic            coreClk,
    input  logic            uctl_rst_n,
    input  logic            sw_rst,
    input  logic            reg2sctrlRx_req,
    input  logic [EPW-1:0]  reg2sctrlRx_epNum,
    input  logic [CNTW-1:0] reg2sctrlRx_rdCount,
    input  logic            reg2sctrlRx_listMode,
    input  logic            reg2sctrlRx_abort,
    output logic            sctrlRx2reg_reqRdy,
    output logic [QLW-1:0]  sctrlRx2reg_qLevel,
    output logic            sctrlRx2reg_updtRdBuf,
    output logic [EPW-1:0]  sctrlRx2reg_doneEp,
    output logic [1:0]      sctrlRx2reg_status,
    output logic [CNTW:0]   sctrlRx2reg_pktsDone,
    input  logic            sepr2sctrlRx_rdPtrsRcvd,
    input  logic            sepr2sctrlRx_bufEmpty,
    input  logic            sepr2sctrlRx_hdrRdDn,
    input  logic            sepr2sctrlRx_transferDn,
    input  logic            sepr2sctrlRx_bufUpdtDn,
    output logic            sctrlRx2sepr_inIdle,
    output logic            sctrlRx2sepr_getRdPtrs,
    output logic            sctrlRx2sepr_hdrRd,
    output logic            sctrlRx2sepr_rd,
    output logic            sctrlRx2sepr_updtRdBuf,
    output logic            sctrlRx2sepr_wrAddrEn,
    output logic [EPW-1:0]  sctrlRx2sepr_epNum
`ifdef UCTL_SCTRLRX_TMO_EN
    ,output logic           sctrlRx2reg_tmo
`endif
);

    sctrlRxState_t        state;
    sctrlRxState_t        stateNxt;
    logic [EPW+CNTW:0]    qWrData;
    logic [EPW+CNTW:0]    qRdData;
    logic                 qFull;
    logic                 qEmpty;
    logic                 pop;
    logic                 busy;
    logic [EPW-1:0]       epNumR;
    logic [CNTW-1:0]      rdCountR;
    logic                 listModeR;
    logic [CNTW:0]        cnt;
    logic [CNTW:0]        cntNxt;
    logic                 abortPend;
    logic                 abortPendNxt;
    logic [1:0]           cmplStatus;
    logic [EPW-1:0]       doneEpR;
    logic [1:0]           statusR;
    logic [CNTW:0]        pktsDoneR;
`ifdef UCTL_SCTRLRX_TMO_EN
    logic [TMOW-1:0]      wdog;
    logic                 tmoFire;
    logic                 tmoR;
`endif

    assign qWrData = {reg2sctrlRx_epNum, reg2sctrlRx_rdCount, reg2sctrlRx_listMode};

    // A request arriving with abort is discarded; abort also empties the queue.
    uctl_sctrlrx_req_fifo #(
        .W      (EPW + CNTW + 1),
        .QDEPTH (QDEPTH),
        .QLW    (QLW)
    ) u_reqFifo (
        .coreClk    (coreClk),
        .uctl_rst_n (uctl_rst_n),
        .flush      (reg2sctrlRx_abort | sw_rst),
        .push       (reg2sctrlRx_req & ~reg2sctrlRx_abort),
        .pop        (pop),
        .wrData     (qWrData),
        .rdData     (qRdData),
        .level      (sctrlRx2reg_qLevel),
        .full       (qFull),
        .empty      (qEmpty)
    );

    assign busy = (state == RDPTR) || (state == RDHDR) || (state == RDDATA) || (state == UPDT);

    assign sctrlRx2reg_reqRdy     = ~qFull;
    assign sctrlRx2reg_updtRdBuf  = (state == CMPL);
    assign sctrlRx2reg_doneEp     = doneEpR;
    assign sctrlRx2reg_status     = busy ? ST_BUSY : statusR;
    assign sctrlRx2reg_pktsDone   = pktsDoneR;
    assign sctrlRx2sepr_inIdle    = (state == IDLE);
    assign sctrlRx2sepr_getRdPtrs = (state == RDPTR);
    assign sctrlRx2sepr_hdrRd     = (state == RDHDR);
    assign sctrlRx2sepr_rd        = (state == RDDATA);
    assign sctrlRx2sepr_updtRdBuf = (state == UPDT);
    assign sctrlRx2sepr_wrAddrEn  = pop;
    assign sctrlRx2sepr_epNum     = epNumR;

    // Next-state, queue pop, packet counter and completion status selection.
    always_comb begin
        stateNxt     = state;
        pop          = 1'b0;
        cntNxt       = cnt;
        abortPendNxt = abortPend;
        cmplStatus   = ST_OK;
`ifdef UCTL_SCTRLRX_TMO_EN
        tmoFire      = 1'b0;
`endif
        case (state)
            IDLE: begin
                abortPendNxt = 1'b0;
                if (!reg2sctrlRx_abort && !qEmpty) begin
                    pop      = 1'b1;
                    cntNxt   = '0;
                    stateNxt = RDPTR;
                end
            end
            RDPTR: begin
                if (reg2sctrlRx_abort) begin
                    stateNxt   = CMPL;
                    cmplStatus = ST_ABORT;
                end else if (sepr2sctrlRx_rdPtrsRcvd) begin
                    if (listModeR) begin
                        stateNxt = CMPL;
                        cntNxt   = '0;
                    end else if (sepr2sctrlRx_bufEmpty) begin
                        stateNxt   = CMPL;
                        cmplStatus = ST_EMPTY;
                    end else begin
                        stateNxt = RDHDR;
                    end
                end
            end
            RDHDR: begin
                if (reg2sctrlRx_abort) begin
                    stateNxt   = CMPL;
                    cmplStatus = ST_ABORT;
                end else if (sepr2sctrlRx_hdrRdDn) begin
                    stateNxt = RDDATA;
                end
            end
            RDDATA: begin
                // Data already in flight: remember the abort and finish the packet.
                if (reg2sctrlRx_abort) abortPendNxt = 1'b1;
                if (sepr2sctrlRx_transferDn) stateNxt = UPDT;
            end
            UPDT: begin
                if (reg2sctrlRx_abort) abortPendNxt = 1'b1;
                if (sepr2sctrlRx_bufUpdtDn) begin
                    cntNxt = cnt + 1'b1;
                    if (reg2sctrlRx_abort || abortPend) begin
                        stateNxt   = CMPL;
                        cmplStatus = ST_ABORT;
                    end else if (cnt == {1'b0, rdCountR}) begin
                        stateNxt = CMPL;
                    end else begin
                        stateNxt = RDPTR;
                    end
                end
            end
            CMPL: begin
                abortPendNxt = 1'b0;
                stateNxt     = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
`ifdef UCTL_SCTRLRX_TMO_EN
        // Watchdog expiry only applies when nothing else moves the FSM this cycle.
        if ((wdog == '1) && busy && (stateNxt == state) && !reg2sctrlRx_abort) begin
            tmoFire    = 1'b1;
            stateNxt   = CMPL;
            cmplStatus = ST_ABORT;
        end
`endif
    end

    // State register, active request context and completion report registers.
    always_ff @(posedge coreClk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            state     <= IDLE;
            epNumR    <= '0;
            rdCountR  <= '0;
            listModeR <= 1'b0;
            cnt       <= '0;
            abortPend <= 1'b0;
            doneEpR   <= '0;
            statusR   <= ST_OK;
            pktsDoneR <= '0;
        end else if (sw_rst) begin
            state     <= IDLE;
            epNumR    <= '0;
            rdCountR  <= '0;
            listModeR <= 1'b0;
            cnt       <= '0;
            abortPend <= 1'b0;
            doneEpR   <= '0;
            statusR   <= ST_OK;
            pktsDoneR <= '0;
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            abortPend <= abortPendNxt;
            if (pop) begin
                epNumR    <= qRdData[EPW+CNTW:CNTW+1];
                rdCountR  <= qRdData[CNTW:1];
                listModeR <= qRdData[0];
            end
            if (stateNxt == CMPL) begin
                doneEpR   <= epNumR;
                statusR   <= cmplStatus;
                pktsDoneR <= cntNxt;
            end
        end
    end

`ifdef UCTL_SCTRLRX_TMO_EN
    // Per-state watchdog, restarted on every state change, saturating at all-ones.
    always_ff @(posedge coreClk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            wdog <= '0;
            tmoR <= 1'b0;
        end else if (sw_rst) begin
            wdog <= '0;
            tmoR <= 1'b0;
        end else begin
            tmoR <= tmoFire;
            if (stateNxt != state) wdog <= '0;
            else if (wdog != '1)   wdog <= wdog + 1'b1;
        end
    end

    assign sctrlRx2reg_tmo = tmoR;
`endif

endmodule
